// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
// Define MDU_BUSY_START_EN to also raise Busy in the cycle that Start is accepted.
module mult_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MADop,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = ($clog2(MAX_CYC + 1) > 4) ? $clog2(MAX_CYC + 1) : 4;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_HIW   = 3'd5;
    localparam logic [2:0] OP_LOW   = 3'd6;

    logic [0:0]       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [31:0]      a_q, a_n, b_q, b_n;
    logic [2:0]       op_q, op_n;
    logic [31:0]      hi_q, hi_n, lo_q, lo_n;

    logic               launch;
    logic               write_en;
    logic signed [63:0] sa64, sb64, prod_s;
    logic [63:0]        prod_u;
    logic signed [31:0] sa32, sb32;
    logic [31:0]        quo_s, rem_s, quo_u, rem_u;
    logic [63:0]        result;

    assign launch = Start && (MADop >= OP_MULT) && (MADop <= OP_DIVU);

    // Arithmetic on the latched operands; evaluated continuously, committed on the last RUN edge.
    assign sa64   = 64'($signed(a_q));
    assign sb64   = 64'($signed(b_q));
    assign prod_s = sa64 * sb64;
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};
    assign sa32   = $signed(a_q);
    assign sb32   = $signed(b_q);
    assign quo_s  = 32'(sa32 / sb32);
    assign rem_s  = 32'(sa32 % sb32);
    assign quo_u  = a_q / b_q;
    assign rem_u  = a_q % b_q;

    // Divide by zero leaves HI/LO untouched.
    assign write_en = (op_q == OP_MULT) || (op_q == OP_MULTU) || (b_q != 32'd0);

    always_comb begin
        result = 64'd0;
        case (op_q)
            OP_MULT:  result = prod_s;
            OP_MULTU: result = prod_u;
            OP_DIV:   result = {rem_s, quo_s};
            OP_DIVU:  result = {rem_u, quo_u};
            default:  result = 64'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            a_q   <= a_n;
            b_q   <= b_n;
            op_q  <= op_n;
            hi_q  <= hi_n;
            lo_q  <= lo_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        a_n     = a_q;
        b_n     = b_q;
        op_n    = op_q;
        hi_n    = hi_q;
        lo_n    = lo_q;
        case (state)
            IDLE: begin
                if (launch) begin
                    a_n     = A;
                    b_n     = B;
                    op_n    = MADop;
                    cnt_n   = (MADop <= OP_MULTU) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                    state_n = RUN;
                end else if (MADop == OP_HIW) begin
                    hi_n = A;
                end else if (MADop == OP_LOW) begin
                    lo_n = A;
                end
            end
            RUN: begin
                cnt_n = cnt - CNT_W'(1);
                if (cnt <= CNT_W'(1)) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                    if (write_en) begin
                        {hi_n, lo_n} = result;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef MDU_BUSY_START_EN
    assign Busy = (state == RUN) || (launch && (state == IDLE));
`else
    assign Busy = (state == RUN);
`endif
    assign HI = hi_q;
    assign LO = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit with a per-cycle reference model and literal result checks.
module tb_mult_div_unit;
    localparam int NM = 5;
    localparam int ND = 10;
`ifdef MDU_BUSY_START_EN
    localparam int BUSY_EXTRA = 1;
`else
    localparam int BUSY_EXTRA = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Start = 1'b0;
    logic [2:0]  MADop = 3'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        Busy;
    logic [31:0] HI, LO;

    int vectors = 0;
    int fails = 0;

    mult_div_unit #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
        .clk(clk), .reset(reset), .Start(Start), .MADop(MADop),
        .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: remaining busy cycles plus the pending architectural result.
    int          m_left = 0;
    logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
    logic        p_valid = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_left = 0; m_hi = 0; m_lo = 0; p_valid = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && p_valid) begin
                m_hi = p_hi; m_lo = p_lo;
            end
        end else if (Start && MADop >= 3'd1 && MADop <= 3'd4) begin
            longint          sl, tl, pl;
            longint unsigned ul, vl, pu;
            int              si, ti, q;
            p_valid = 1;
            case (MADop)
                3'd1: begin
                    sl = longint'(int'(A)); tl = longint'(int'(B)); pl = sl * tl;
                    {p_hi, p_lo} = pl;
                end
                3'd2: begin
                    ul = A; vl = B; pu = ul * vl;
                    {p_hi, p_lo} = pu;
                end
                3'd3: begin
                    if (B == 0) p_valid = 0;
                    else begin
                        si = int'(A); ti = int'(B); q = si / ti;
                        p_lo = q; p_hi = si - q * ti;
                    end
                end
                default: begin
                    if (B == 0) p_valid = 0;
                    else begin
                        p_lo = A / B; p_hi = A - (A / B) * B;
                    end
                end
            endcase
            m_left = (MADop <= 3'd2) ? NM : ND;
        end else if (MADop == 3'd5) begin
            m_hi = A;
        end else if (MADop == 3'd6) begin
            m_lo = A;
        end
    end

    always @(negedge clk) begin
        logic eb;
        eb = (m_left > 0);
`ifdef MDU_BUSY_START_EN
        eb = eb || (Start && MADop >= 3'd1 && MADop <= 3'd4 && m_left == 0 && !reset);
`endif
        chk("model_busy", 32'(Busy), 32'(eb));
        chk("model_hi", HI, m_hi);
        chk("model_lo", LO, m_lo);
    end

    // Launch one op at posedge+1 and measure the Busy length; optional noise hits RUN.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int n_exp, input bit noise);
        int n;
        n = 0;
        Start = 1'b1; MADop = o; A = a; B = b;
        @(negedge clk);
        if (Busy) n++;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (noise && i < 4) begin
                Start = (i % 2 == 0); MADop = (i % 2 == 0) ? 3'd1 : 3'd5;
                A = 32'hDEADBEEF; B = 32'd3;
            end else begin
                Start = 1'b0; MADop = 3'd0; A = 32'd0; B = 32'd0;
            end
            @(negedge clk);
            if (Busy) n++;
            else break;
        end
        chk("busy_len", 32'(n), 32'(n_exp + BUSY_EXTRA));
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [2:0] o, input logic [31:0] a);
        MADop = o; A = a;
        @(posedge clk); #1;
        MADop = 3'd0; A = 32'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_op(3'd1, 32'hFFFFFFFE, 32'd3, NM, 0);
        chk("mult_hi", HI, 32'hFFFFFFFF);
        chk("mult_lo", LO, 32'hFFFFFFFA);

        run_op(3'd2, 32'hFFFFFFFF, 32'd2, NM, 0);
        chk("multu_hi", HI, 32'h00000001);
        chk("multu_lo", LO, 32'hFFFFFFFE);

        run_op(3'd3, 32'hFFFFFFF9, 32'd2, ND, 0);
        chk("div_hi", HI, 32'hFFFFFFFF);
        chk("div_lo", LO, 32'hFFFFFFFD);

        run_op(3'd4, 32'd7, 32'd2, ND, 0);
        chk("divu_hi", HI, 32'd1);
        chk("divu_lo", LO, 32'd3);

        run_op(3'd3, 32'd7, 32'hFFFFFFFE, ND, 0);
        chk("div_negdiv_hi", HI, 32'd1);
        chk("div_negdiv_lo", LO, 32'hFFFFFFFD);

        run_op(3'd1, 32'h80000000, 32'h80000000, NM, 0);
        chk("mult_min_hi", HI, 32'h40000000);
        chk("mult_min_lo", LO, 32'h00000000);

        run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, NM, 0);
        chk("multu_max_hi", HI, 32'hFFFFFFFE);
        chk("multu_max_lo", LO, 32'h00000001);

        // Start with non-launching opcodes
        Start = 1'b1; MADop = 3'd7; A = 32'h55; B = 32'h2;
        @(posedge clk); #1;
        MADop = 3'd0;
        @(posedge clk); #1;
        Start = 1'b0;
        chk("noop_busy", 32'(Busy), 32'd0);
        chk("noop_hi", HI, 32'hFFFFFFFE);

        wr(3'd5, 32'h12345678);
        chk("hiw_hi", HI, 32'h12345678);
        chk("hiw_busy", 32'(Busy), 32'd0);
        wr(3'd6, 32'h00000009);
        chk("low_lo", LO, 32'h00000009);
        chk("low_hi", HI, 32'h12345678);

        run_op(3'd3, 32'd100, 32'd7, ND, 1);
        chk("div_noise_hi", HI, 32'd2);
        chk("div_noise_lo", LO, 32'd14);

        wr(3'd5, 32'hA);
        wr(3'd6, 32'hB);
        run_op(3'd3, 32'd123, 32'd0, ND, 1);
        chk("div0_hi", HI, 32'hA);
        chk("div0_lo", LO, 32'hB);

        // Reset during the third RUN cycle of a MULT
        Start = 1'b1; MADop = 3'd1; A = 32'd6; B = 32'd7;
        @(posedge clk); #1;
        Start = 1'b0; MADop = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("pre_rst_busy", 32'(Busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_busy", 32'(Busy), 32'd0);
        chk("abort_hi", HI, 32'd0);
        chk("abort_lo", LO, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("abort_hi_later", HI, 32'd0);

        run_op(3'd1, 32'hFFFFFFFE, 32'd3, NM, 0);
        chk("mult2_hi", HI, 32'hFFFFFFFF);
        chk("mult2_lo", LO, 32'hFFFFFFFA);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have parameter MULT_CYCLES, default 5: Busy cycles for mult/multu.
REQ-002 The block SHALL have parameter DIV_CYCLES, default 10: Busy cycles for div/divu.
REQ-003 The block SHALL have input clk, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have input reset, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have input Start, 1 bit: E-stage pulse launching a mult/multu/div/divu.
REQ-006 The block SHALL have input MADop, 3 bits: 0 default, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 HI_Write, 6 LO_Write, 7 reserved (treated as default).
REQ-007 The block SHALL have input A, 32 bits: forwarded rs operand.
REQ-008 The block SHALL have input B, 32 bits: forwarded rt operand.
REQ-009 The block SHALL have output Busy, 1 bit: operation in flight; the hazard unit stalls any HILO instruction in D while Busy is high.
REQ-010 The block SHALL have output HI, 32 bits: committed HI register.
REQ-011 The block SHALL have output LO, 32 bits: committed LO register.

Function
REQ-012 States SHALL be IDLE and RUN, with a down-counter cnt of at least 4 bits.
REQ-013 In IDLE, when Start=1 and MADop is 1-4, the block SHALL latch A, B and MADop, load cnt with MULT_CYCLES or DIV_CYCLES, and enter RUN.
REQ-014 In RUN, cnt SHALL decrement each cycle; at the edge where cnt goes 1->0, the block SHALL write the result to HI/LO and return to IDLE.
REQ-015 HI/LO SHALL hold their old values during RUN; the result is visible on the first cycle after Busy falls.
REQ-016 MULT SHALL give {HI,LO} = signed 64-bit A*B; MULTU SHALL give the unsigned 64-bit product.
REQ-017 DIV SHALL give LO = signed quotient truncated toward zero and HI = remainder carrying the sign of the dividend; DIVU SHALL give the unsigned quotient and remainder.
REQ-018 On divide by zero (latched B=0), HI and LO SHALL be left unchanged while the full DIV_CYCLES Busy period is still spent.
REQ-019 HI_Write SHALL set HI<=A and LO_Write SHALL set LO<=A at the next edge, without Start, with no Busy, and only in IDLE.
REQ-020 Start, HI_Write and LO_Write SHALL be ignored while in RUN; the latched operands SHALL not change.
REQ-021 Start with MADop of 0 or 5-7 SHALL not launch an operation.
REQ-022 Busy SHALL equal (state==RUN) when MDU_BUSY_START_EN is undefined.

Reset
REQ-023 Reset SHALL force state IDLE, cnt=0, HI=0, LO=0, Busy=0, and latched operands to 0, immediately and independently of clk.
REQ-024 Reset asserted mid-operation SHALL abort the operation; no result is written and HI/LO read 0.

Configuration
REQ-025 The macro SHALL be named MDU_BUSY_START_EN.
REQ-026 With MDU_BUSY_START_EN defined, Busy SHALL equal (state==RUN) | (Start & MADop in 1..4 & state==IDLE), so Busy is high in the Start cycle and the total Busy length is N+1 cycles.
REQ-027 With MDU_BUSY_START_EN undefined, Busy SHALL be purely registered, low in the Start cycle, and high for exactly N cycles.

Verification
REQ-028 Scenario 1: MULT with A=0xFFFFFFFE (-2), B=3 -> Busy high for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-029 Scenario 2: MULTU with A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 Busy cycles.
REQ-030 Scenario 3: DIV with A=-7 (0xFFFFFFF9), B=2 -> 10 Busy cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU with A=7, B=2 -> LO=3, HI=1.
REQ-031 Scenario 4: HI_Write with A=0x12345678, then LO_Write with A=0x9 -> HI and LO update on the next edge and Busy stays 0. A further HI_Write issued during a DIV -> HI unchanged.
REQ-032 Scenario 5: DIV with B=0 while HI=0xA and LO=0xB -> Busy 10 cycles, HI=0xA, LO=0xB. A second Start during RUN -> no effect on the result or timing.
REQ-033 Scenario 6: assert reset at cycle 3 of a MULT -> Busy=0, HI=LO=0 immediately. Repeat scenario 1 with MDU_BUSY_START_EN -> Busy high in the Start cycle and for 6 cycles total.
